// File: rtl/mux_row_loader.sv
// Frame sequencer for one LED driver group: walks 4 mux rows x all driver outputs,
// fetches each LED's colour word via the row LUT and column RAM, shifts it out, latches and switches rows.
module mux_row_loader #(
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int NB_LED_ROWS       = 32,
  parameter int DATA_WIDTH        = 48,
  localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP),
  localparam int LED_ROW_WIDTH    = $clog2(NB_LED_ROWS)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start_frame,
  output logic [3:0]               lut_row_en,
  output logic [LED_WIDTH-1:0]     led,
  input  logic [LED_ROW_WIDTH-1:0] led_row,
  output logic                     rd_en,
  output logic [LED_ROW_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     sout,
  output logic                     sclk,
  output logic                     lat,
  output logic [3:0]               row_en,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic [2:0] {IDLE, ADDR, REQ, LOAD, SHIFT, LATCH, SWITCH} state_t;

  localparam int CNT_W = $clog2(2 * DATA_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(2 * DATA_WIDTH - 1);
  localparam logic [LED_WIDTH-1:0] LED_LAST = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);

  state_t                   state, state_nxt;
  logic [3:0]               lut_row_en_nxt, row_en_nxt;
  logic [LED_WIDTH-1:0]     led_nxt;
  logic [LED_ROW_WIDTH-1:0] rd_addr_nxt;
  logic                     rd_en_nxt, sout_nxt, sclk_nxt, lat_nxt, busy_nxt, frame_done_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]    shreg, shreg_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      lut_row_en <= 4'b0001;
      led        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      sout       <= 1'b0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      row_en     <= 4'b0000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      lut_row_en <= lut_row_en_nxt;
      led        <= led_nxt;
      rd_en      <= rd_en_nxt;
      rd_addr    <= rd_addr_nxt;
      sout       <= sout_nxt;
      sclk       <= sclk_nxt;
      lat        <= lat_nxt;
      row_en     <= row_en_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Colour word is pure data and needs no reset
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt      = state;
    lut_row_en_nxt = lut_row_en;
    led_nxt        = led;
    rd_en_nxt      = 1'b0;
    rd_addr_nxt    = rd_addr;
    sout_nxt       = sout;
    sclk_nxt       = sclk;
    lat_nxt        = lat;
    row_en_nxt     = row_en;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    case (state)
      IDLE: begin
        if (start_frame) begin
          busy_nxt       = 1'b1;
          lut_row_en_nxt = 4'b0001;
          led_nxt        = LED_LAST;
          state_nxt      = ADDR;
        end
      end
      ADDR: begin
        rd_addr_nxt = led_row;
        rd_en_nxt   = 1'b1;
        state_nxt   = REQ;
      end
      REQ: state_nxt = LOAD;
      LOAD: begin
        shreg_nxt = rd_data;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        cnt_nxt = cnt + 1'b1;
        if (!cnt[0]) begin
          sout_nxt = shreg[DATA_WIDTH-1];
          sclk_nxt = 1'b0;
        end else begin
          // Rising sclk edge; sout has been stable since the preceding low phase
          sclk_nxt  = 1'b1;
          shreg_nxt = shreg << 1;
          if (cnt == CNT_LAST) begin
            if (led != '0) begin
              led_nxt   = led - 1'b1;
              state_nxt = ADDR;
            end else begin
              state_nxt = LATCH;
            end
          end
        end
      end
      LATCH: begin
        lat_nxt    = 1'b1;
        row_en_nxt = 4'b0000;
        sclk_nxt   = 1'b0;
        state_nxt  = SWITCH;
      end
      SWITCH: begin
        lat_nxt    = 1'b0;
        row_en_nxt = lut_row_en;
        if (lut_row_en[3]) begin
          busy_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
          lut_row_en_nxt = 4'b0001;
          state_nxt      = IDLE;
        end else begin
          lut_row_en_nxt = {lut_row_en[2:0], lut_row_en[3]};
          led_nxt        = LED_LAST;
          state_nxt      = ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_row_loader.sv
// Scoreboard bench for mux_row_loader: LUT and column RAM models, serial capture, frame timing, reset.
module tb_mux_row_loader;

  localparam int NL    = 16;
  localparam int NR    = 32;
  localparam int DW    = 4;
  localparam int FRAME = 712;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_frame = 1'b0;
  logic [3:0]  lut_row_en;
  logic [3:0]  led;
  logic [4:0]  led_row;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_data = '0;
  logic        sout, sclk, lat, busy, frame_done;
  logic [3:0]  row_en;

  mux_row_loader #(.NB_LEDS_PER_GROUP(NL), .NB_LED_ROWS(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .nrst(nrst), .start_frame(start_frame),
    .lut_row_en(lut_row_en), .led(led), .led_row(led_row),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sout(sout), .sclk(sclk), .lat(lat), .row_en(row_en),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lookup table: an arbitrary scrambling of (row, led) into physical rows
  function automatic logic [4:0] lut_fn(input logic [3:0] oh, input logic [3:0] l);
    int r;
    case (oh)
      4'b0001: r = 0;
      4'b0010: r = 1;
      4'b0100: r = 2;
      4'b1000: r = 3;
      default: r = 5;
    endcase
    return 5'((int'(l) * 7 + r * 9 + 2) % 32);
  endfunction
  assign led_row = lut_fn(lut_row_en, led);

  // Column RAM: one-cycle read latency, word = low bits of the address
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[3:0];

  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  logic [4:0] exp_addr_q[$];
  logic [3:0] exp_word_q[$];
  int start_edge = 0;
  int reads, lat_seen, row_rises, nbits;
  logic [3:0] sh;
  logic sclk_prev = 1'b0;
  logic lat_prev = 1'b0;

  task automatic sample();
    logic [4:0] ea;
    logic [3:0] ew;
    logic [3:0] eo;
    if (rd_en) begin
      if (reads == 0) begin
        check("rd_en_cycles_after_start", 32'(cyc - start_edge + 1), 32'd2);
        check("busy_in_frame", 32'(busy), 32'd1);
      end
      if (exp_addr_q.size() == 0) check("extra_read", 32'(rd_addr), 32'hffff_ffff);
      else begin
        ea = exp_addr_q.pop_front();
        check("rd_addr", 32'(rd_addr), 32'(ea));
        exp_word_q.push_back(ea[3:0]);
      end
      reads++;
    end
    if (sclk && !sclk_prev) begin
      sh = {sh[2:0], sout};
      nbits++;
      row_rises++;
      if (nbits == DW) begin
        nbits = 0;
        if (exp_word_q.size() == 0) check("extra_word", 32'(sh), 32'hffff_ffff);
        else begin
          ew = exp_word_q.pop_front();
          check("sout_word", 32'(sh), 32'(ew));
        end
      end
    end
    if (lat) begin
      check("lat_width", 32'(lat_prev), 32'd0);
      if (!lat_prev) begin
        check("lat_row_en", 32'(row_en), 32'd0);
        check("lat_sclk", 32'(sclk), 32'd0);
        check("row_sclk_rises", 32'(row_rises), 32'd64);
        row_rises = 0;
        lat_seen++;
      end
    end
    if (lat_prev && !lat) begin
      eo = 4'b0001 << (lat_seen - 1);
      check("row_en_after_lat", 32'(row_en), 32'(eo));
    end
    sclk_prev = sclk;
    lat_prev  = lat;
  endtask

  task automatic kick();
    @(posedge clk); #1 start_frame = 1'b1;
    @(posedge clk); #1 start_edge = cyc; start_frame = 1'b0;
    reads = 0; lat_seen = 0; row_rises = 0; nbits = 0; sh = '0;
    exp_addr_q.delete();
    exp_word_q.delete();
    for (int r = 0; r < 4; r++)
      for (int l = NL - 1; l >= 0; l--)
        exp_addr_q.push_back(lut_fn(4'b0001 << r, 4'(l)));
  endtask

  // Runs until frame_done; inj1/inj2 are cycles (relative to start) that pulse start_frame
  task automatic wait_done(input int inj1, input int inj2);
    int n;
    int rel;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
      sample();
      rel = cyc - start_edge;
      start_frame = (rel == inj1) || (rel == inj2);
      if (frame_done) begin
        seen = 1'b1;
        check("frame_len", 32'(rel), 32'(FRAME));
        check("reads_per_frame", 32'(reads), 32'd64);
        check("lats_per_frame", 32'(lat_seen), 32'd4);
        check("idle_row_en", 32'(row_en), 32'h8);
        check("idle_lut_row_en", 32'(lut_row_en), 32'h1);
        check("idle_busy", 32'(busy), 32'd0);
        check("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
      end
    end
    start_frame = 1'b0;
    if (!seen) check("frame_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lut_row_en"}, 32'(lut_row_en), 32'h1);
    check({tag, "_led"},        32'(led), 32'd0);
    check({tag, "_rd_en"},      32'(rd_en), 32'd0);
    check({tag, "_rd_addr"},    32'(rd_addr), 32'd0);
    check({tag, "_sout"},       32'(sout), 32'd0);
    check({tag, "_sclk"},       32'(sclk), 32'd0);
    check({tag, "_lat"},        32'(lat), 32'd0);
    check({tag, "_row_en"},     32'(row_en), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk) nrst = 1'b1;

    kick();
    wait_done(-1, -1);
    // Start again in the cycle right after frame_done
    kick();
    wait_done(-1, -1);
    // Stray start pulses during a frame are dropped
    kick();
    wait_done(5, 300);

    // Reset in the middle of row 2 shifting
    kick();
    for (int n = 0; n < 416; n++) begin
      @(negedge clk);
      sample();
    end
    check("pre_reset_row_en", 32'(row_en), 32'h2);
    nrst = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    sclk_prev = 1'b0;
    lat_prev  = 1'b0;
    kick();
    wait_done(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
